uart_echo_responder: RTL and testbench
======================================

Name: uart_echo_responder

Overview:
- Remote-end responder for the UART link. It takes completed bytes from the receiver side (rx_done/rx_data) and buffers them in a FIFO.
- It retransmits each accepted byte through the transmitter side using the tx_start/tx_data/tx_done handshake.
- It sits between a UartRx instance and a UartTx instance, forming a hardware loopback peer for link bring-up and bench self-checking.

Parameters:
- DATA_BITS, 8, width of rx_data/tx_data and of each FIFO entry.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- GAP_CYCLES, 2, idle clk cycles inserted after each tx_done before the next tx_start; 0 allowed.
- TX_TIMEOUT, 4096, clk cycles to wait for tx_done; used only with UART_ECHO_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous.
- echo_en  input  1  1 = FIFO entries may be popped and transmitted; 0 = hold.
- rx_done  input  1  one-cycle pulse: rx_data holds a complete byte.
- rx_data  input  DATA_BITS  received byte, valid when rx_done=1.
- rx_err  input  1  qualifies rx_done; 1 = byte has a parity or framing error and is discarded.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  DATA_BITS  byte to transmit; stable from the tx_start cycle until the next pop.
- tx_done  input  1  one-cycle pulse from the transmitter at end of frame.
- clr_flags  input  1  synchronous clear of the sticky flags.
- busy  output  1  1 whenever the FSM is not IDLE.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a valid byte arrived while the FIFO was full.
- err_drop  output  1  sticky: a byte with rx_err=1 was discarded.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO pointers and fifo_count go to 0.
  - FSM goes to IDLE.
  - tx_start=0, tx_data=0, busy=0, overflow=0, err_drop=0.
  - Reset mid-frame abandons the frame and discards all buffered bytes.
- Push:
  - A push occurs on the rx_done=1 & rx_err=0 & !full edge.
  - rx_done=1 & rx_err=1 sets err_drop; nothing is written.
  - rx_done=1 & rx_err=0 & full sets overflow; the byte is dropped.
  - Exception: if a pop occurs in the same cycle, the push is accepted and fifo_count stays at DEPTH.
- Pointers: wr_ptr and rd_ptr wrap modulo DEPTH. full is fifo_count==DEPTH; empty is fifo_count==0.
- Simultaneous push and pop leaves fifo_count unchanged. Push on empty followed by a pop the next cycle is legal; there is no same-cycle bypass.
- clr_flags=1 clears overflow and err_drop. If a set condition occurs in the same cycle, set wins.
- FSM states:
  - IDLE: if echo_en & !empty, pop the head into the tx_data register and go to START. Otherwise stay.
  - START: tx_start=1 for exactly this cycle; go to WAIT.
  - WAIT: tx_done is sampled only in this state. On tx_done, go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: counter runs 0..GAP_CYCLES-1, then go to IDLE.
- tx_done outside WAIT is ignored.
- Latency: rx_done in cycle N (empty FIFO, echo_en=1) gives fifo_count=1 in N+1 and tx_start=1 in cycle N+2.
- echo_en=0 mid-frame: the current frame and GAP complete normally; no further pops occur until echo_en=1.
- Byte order out equals accepted byte order in, with no duplication.

Optional Feature:
- Macro: UART_ECHO_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TX_TIMEOUT cycles elapse without tx_done, the FSM goes to IDLE and the byte is considered lost.
  - Sticky output tx_timeout (1 bit) is set; it is cleared by clr_flags and by reset.
  - The counter resets on each entry to WAIT.
- Not defined:
  - WAIT holds indefinitely until tx_done.
  - The tx_timeout port does not exist.

Test Plan:
- Single byte: reset, echo_en=1, rx_done with rx_data=8'h55, model tx_done 100 cycles after tx_start -> tx_start pulse 2 cycles after rx_done, tx_data=8'h55, busy 1 until GAP ends, fifo_count back to 0.
- Burst/order: echo_en=0, push 8'hFF, 8'h00, 8'hA5 -> fifo_count=3; set echo_en=1 -> three tx_start pulses carrying FF, 00, A5 in order, each separated by at least GAP_CYCLES after tx_done.
- Overflow: echo_en=0, push 9 bytes (01..09) with DEPTH=8 -> fifo_count=8, overflow=1; drained output is 01..08. Pulse clr_flags -> overflow=0.
- Full with simultaneous pop/push: FIFO full, IDLE pop coincides with rx_done 8'h3C -> push accepted, fifo_count stays 8, overflow stays 0, 8'h3C is transmitted last.
- Error drop and stray done: rx_done with rx_err=1 (8'h77) -> err_drop=1, fifo_count=0, no tx_start. A tx_done pulse while IDLE causes no state change.
- Reset mid-frame (and timeout build): assert rst_n=0 in WAIT with 3 queued bytes -> all outputs zero immediately, no tx_start after release. With UART_ECHO_TIMEOUT_EN and TX_TIMEOUT=16, withhold tx_done -> tx_timeout=1 and FSM in IDLE 16 cycles after START.

Source files
------------

// File: rtl/uart_echo_responder.sv
// UART loopback peer: buffers error-free received bytes in a FIFO and re-sends them in order.
// Optional feature macro UART_ECHO_TIMEOUT_EN adds a tx_done watchdog with a sticky tx_timeout flag.
module uart_echo_responder #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TX_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   echo_en,
    input  logic                   rx_done,
    input  logic [DATA_BITS-1:0]   rx_data,
    input  logic                   rx_err,
    output logic                   tx_start,
    output logic [DATA_BITS-1:0]   tx_data,
    input  logic                   tx_done,
    input  logic                   clr_flags,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   err_drop
`ifdef UART_ECHO_TIMEOUT_EN
    ,
    output logic                   tx_timeout
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TX_TIMEOUT == 0) begin : g_bad_cfg
        $error("uart_echo_responder: DEPTH must be a power of 2 >= 2 and TX_TIMEOUT > 0");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e                 state_q;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [GW-1:0]          gap_cnt_q;
    logic [DATA_BITS-1:0]   tx_data_q;
    logic                   tx_start_q;
    logic                   busy_q;
    logic                   overflow_q, overflow_d;
    logic                   err_drop_q, err_drop_d;

    logic full_c;
    logic empty_c;
    logic rx_ok_c;
    logic pop_c;
    logic push_c;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign rx_ok_c = rx_done && !rx_err;
    assign pop_c   = (state_q == ST_IDLE) && echo_en && !empty_c;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_c  = rx_ok_c && (!full_c || pop_c);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = (rx_ok_c && full_c && !pop_c) || (overflow_q && !clr_flags);
        err_drop_d = (rx_done && rx_err) || (err_drop_q && !clr_flags);
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_drop_q <= err_drop_d;
        end
    end

`ifdef UART_ECHO_TIMEOUT_EN
    localparam int unsigned TOW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    logic [TOW-1:0] to_cnt_q;
    logic           tx_timeout_q;
    logic           timeout_hit_c;

    assign timeout_hit_c = (state_q == ST_WAIT) && !tx_done && (to_cnt_q == TOW'(TX_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_timeout_q <= 1'b0;
        end else begin
            tx_timeout_q <= timeout_hit_c || (tx_timeout_q && !clr_flags);
        end
    end

    assign tx_timeout = tx_timeout_q;
`endif

    // Transmit sequencer: pop -> one-cycle start -> wait for done -> inter-frame gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            gap_cnt_q  <= '0;
`ifdef UART_ECHO_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pop_c) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
`ifdef UART_ECHO_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_q <= '0;
                            state_q   <= ST_GAP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
`ifdef UART_ECHO_TIMEOUT_EN
                    else if (timeout_hit_c) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TOW'(1);
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt_q == GW'(GAP_LAST)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign err_drop   = err_drop_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_uart_echo_responder;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          echo_en = 1'b0;
    logic          rx_done = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_err = 1'b0;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_done = 1'b0;
    logic          clr_flags = 1'b0;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          err_drop;
`ifdef UART_ECHO_TIMEOUT_EN
    logic          tx_timeout;
`endif

    uart_echo_responder #(
        .DATA_BITS (DW),
        .DEPTH     (DEPTH),
        .GAP_CYCLES(GAP),
        .TX_TIMEOUT(4096)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .echo_en   (echo_en),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .clr_flags (clr_flags),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .err_drop  (err_drop)
`ifdef UART_ECHO_TIMEOUT_EN
        ,
        .tx_timeout(tx_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents plus where the current frame sits on its timeline.
    byte unsigned mq[$];
    bit           m_start, m_busy, m_wait, m_ovf, m_err;
    int           m_gap;
    logic [DW-1:0] m_data;

    byte unsigned dut_log[$];
    int tests = 0;
    int fails = 0;
    int tick_no = 0;
    int first_start_tick = -1;
    int done_in = 0;
    int fixed_delay = 0;

    bit           s_en = 1'b0;
    bit           s_rx = 1'b0;
    bit           s_err = 1'b0;
    bit           s_clr = 1'b0;
    bit           s_stray = 1'b0;
    logic [DW-1:0] s_data = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_no);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_start = 1'b0;
        m_busy  = 1'b0;
        m_wait  = 1'b0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_gap   = 0;
        m_data  = '0;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    function automatic void model_step();
        bit full, rxok, pop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        full = (mq.size() == DEPTH);
        rxok = rx_done && !rx_err;
        pop  = !m_busy && echo_en && (mq.size() > 0);
        m_ovf = (rxok && full && !pop) || (m_ovf && !clr_flags);
        m_err = (rx_done && rx_err) || (m_err && !clr_flags);
        if (m_start) begin
            m_start = 1'b0;
            m_wait  = 1'b1;
        end else if (m_wait) begin
            if (tx_done) begin
                m_wait = 1'b0;
                m_gap  = GAP;
                if (GAP == 0) m_busy = 1'b0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_busy = 1'b0;
        end
        if (pop) begin
            m_data  = mq.pop_front();
            m_start = 1'b1;
            m_busy  = 1'b1;
        end
        if (rxok && (!full || pop)) mq.push_back(rx_data);
    endfunction

    task automatic check_outputs();
        cmp("tx_start", 32'(tx_start), 32'(m_start));
        cmp("tx_data", 32'(tx_data), 32'(m_data));
        cmp("busy", 32'(busy), 32'(m_busy));
        cmp("fifo_count", 32'(fifo_count), 32'(mq.size()));
        cmp("overflow", 32'(overflow), 32'(m_ovf));
        cmp("err_drop", 32'(err_drop), 32'(m_err));
`ifdef UART_ECHO_TIMEOUT_EN
        cmp("tx_timeout", 32'(tx_timeout), 32'(0));
`endif
        if (tx_start === 1'b1) begin
            dut_log.push_back(tx_data);
            if (first_start_tick < 0) first_start_tick = tick_no;
        end
    endtask

    // One clock: compare at the falling edge, then drive the next cycle's inputs.
    task automatic tick();
        @(negedge clk);
        tick_no++;
        check_outputs();
        tx_done = 1'b0;
        if (done_in > 0) begin
            done_in--;
            if (done_in == 0) tx_done = 1'b1;
        end else if (s_stray) begin
            tx_done = 1'b1;
        end
        if (m_start) done_in = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 20));
        echo_en   = s_en;
        rx_done   = s_rx;
        rx_err    = s_err;
        rx_data   = s_data;
        clr_flags = s_clr;
        s_rx = 1'b0;
        s_err = 1'b0;
        s_clr = 1'b0;
        s_stray = 1'b0;
        model_step();
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        s_rx = 1'b1;
        s_data = b;
        tick();
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        s_en = 1'b1;
        do begin
            tick();
            n++;
        end while ((busy !== 1'b0 || fifo_count !== '0) && n < 3000);
        cmp("drain_bound", 32'(n < 3000), 32'(1));
        repeat (3) tick();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        cmp("rst_tx_start", 32'(tx_start), 32'(0));
        cmp("rst_tx_data", 32'(tx_data), 32'(0));
        cmp("rst_busy", 32'(busy), 32'(0));
        cmp("rst_count", 32'(fifo_count), 32'(0));
        cmp("rst_ovf", 32'(overflow), 32'(0));
        cmp("rst_err", 32'(err_drop), 32'(0));
        model_reset();
        done_in = 0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx_tick;
        int n;
        byte unsigned exp_burst[3];
        exp_burst[0] = 8'hFF;
        exp_burst[1] = 8'h00;
        exp_burst[2] = 8'hA5;

        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // Single byte with a slow transmitter.
        s_en = 1'b1;
        fixed_delay = 100;
        first_start_tick = -1;
        dut_log.delete();
        s_rx = 1'b1;
        s_data = 8'h55;
        tick();
        rx_tick = tick_no;
        tick();
        cmp("lat_count1", 32'(fifo_count), 32'(1));
        repeat (120) tick();
        cmp("lat_start", 32'(first_start_tick - rx_tick), 32'(2));
        cmp("single_n", 32'(dut_log.size()), 32'(1));
        cmp("single_byte", 32'(dut_log[0]), 32'h55);
        cmp("single_idle", 32'(busy), 32'(0));
        cmp("single_empty", 32'(fifo_count), 32'(0));
        fixed_delay = 0;

        // Burst held back, then released in order.
        s_en = 1'b0;
        foreach (exp_burst[i]) push_byte(exp_burst[i]);
        cmp("burst_count", 32'(fifo_count), 32'(3));
        cmp("model_burst", 32'(mq.size()), 32'(3));
        dut_log.delete();
        drain();
        cmp("burst_n", 32'(dut_log.size()), 32'(3));
        for (int i = 0; i < 3; i++) cmp("burst_order", 32'(dut_log[i]), 32'(exp_burst[i]));

        // Overflow: nine bytes into an eight-entry FIFO.
        s_en = 1'b0;
        for (int i = 1; i <= 9; i++) push_byte(DW'(i));
        cmp("ovf_count", 32'(fifo_count), 32'(8));
        cmp("ovf_flag", 32'(overflow), 32'(1));
        s_clr = 1'b1;
        tick();
        tick();
        cmp("ovf_clr", 32'(overflow), 32'(0));
        dut_log.delete();
        drain();
        cmp("ovf_n", 32'(dut_log.size()), 32'(8));
        for (int i = 0; i < 8; i++) cmp("ovf_order", 32'(dut_log[i]), 32'(i + 1));

        // Full FIFO: pop and push land on the same edge.
        s_en = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(DW'(8'h11 + i));
        cmp("full_count", 32'(fifo_count), 32'(8));
        dut_log.delete();
        s_en = 1'b1;
        s_rx = 1'b1;
        s_data = 8'h3C;
        tick();
        tick();
        cmp("pp_count", 32'(fifo_count), 32'(8));
        cmp("pp_ovf", 32'(overflow), 32'(0));
        drain();
        cmp("pp_n", 32'(dut_log.size()), 32'(9));
        cmp("pp_last", 32'(dut_log[8]), 32'h3C);

        // Errored byte is dropped; stray tx_done in IDLE is ignored.
        dut_log.delete();
        s_err = 1'b1;
        push_byte(8'h77);
        cmp("err_flag", 32'(err_drop), 32'(1));
        cmp("err_count", 32'(fifo_count), 32'(0));
        repeat (5) tick();
        cmp("err_no_tx", 32'(dut_log.size()), 32'(0));
        s_stray = 1'b1;
        tick();
        tick();
        cmp("stray_busy", 32'(busy), 32'(0));
        s_clr = 1'b1;
        tick();
        tick();
        cmp("err_clr", 32'(err_drop), 32'(0));

        // Reset while a frame is waiting for tx_done with three bytes queued.
        fixed_delay = 100;
        s_en = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(DW'(8'hA0 + i));
        dut_log.delete();
        s_en = 1'b1;
        n = 0;
        while (dut_log.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        cmp("mid_start_seen", 32'(n < 50), 32'(1));
        repeat (3) tick();
        cmp("mid_queued", 32'(fifo_count), 32'(3));
        async_reset();
        dut_log.delete();
        repeat (20) tick();
        cmp("post_rst_no_tx", 32'(dut_log.size()), 32'(0));
        cmp("post_rst_count", 32'(fifo_count), 32'(0));
        fixed_delay = 0;

        // Randomized traffic.
        s_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) s_en = ~s_en;
            if ($urandom_range(0, 99) < 30) begin
                s_rx = 1'b1;
                s_data = DW'($urandom);
                s_err = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 99) < 2) s_clr = 1'b1;
            if ($urandom_range(0, 99) < 3) s_stray = 1'b1;
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
